// File: rtl/branch_pkg.sv
// Shared types for branch resolution: opcode encoding, stage state, PC increment.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_BEQ = 3'b000,
    BR_BNE = 3'b001,
    BR_BLT = 3'b010,
    BR_BGE = 3'b011,
    BR_JAL = 3'b100
  } br_op_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational branch direction decode from comparator flags and opcode.
module branch_cond_decode
  import branch_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       Equal,
  input  logic       Z,
  input  logic       N,
  output logic       taken,
  output logic       illegal
);

  // Equal and Z are used independently; their consistency is the comparator's concern.
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_op)
      BR_BEQ:  taken = Equal;
      BR_BNE:  taken = Z;
      BR_BLT:  taken = N;
      BR_BGE:  taken = !N;
      BR_JAL:  taken = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Single registered branch-resolve stage: direction, target/next PC, mispredict,
// valid/ready handshake with flush, and saturating branch/mispredict counters.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             Equal,
  input  logic             Z,
  input  logic             N,
  input  logic [2:0]       br_op,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             illegal,
  output logic [XLEN-1:0]  target,
  output logic [XLEN-1:0]  next_pc,
  output logic             mispredict,
  output logic             redirect,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  state_t          state;
  logic            accept, xfer;
  logic            dec_taken, dec_illegal;
  logic [XLEN-1:0] sum, seq_pc;

  branch_cond_decode u_dec (
    .br_op   (br_op),
    .Equal   (Equal),
    .Z       (Z),
    .N       (N),
    .taken   (dec_taken),
    .illegal (dec_illegal)
  );

  assign out_valid = (state == ST_FULL);
  assign in_ready  = !out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign redirect  = out_valid & mispredict;
  assign sum       = pc + imm;
  assign seq_pc    = pc + XLEN'(PC_INC);

  // Flush overrides everything, including a same-cycle accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept)         state <= ST_FULL;
        ST_FULL:  if (xfer && !accept) state <= ST_EMPTY;
        default:                       state <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken      <= 1'b0;
      illegal    <= 1'b0;
      target     <= '0;
      next_pc    <= '0;
      mispredict <= 1'b0;
    end else if (accept && !flush) begin
      taken      <= dec_taken;
      illegal    <= dec_illegal;
      target     <= sum;
      next_pc    <= dec_taken ? sum : seq_pc;
      mispredict <= dec_taken ^ pred_taken;
    end
  end

  // A transfer that coincides with a flush was seen downstream, so it still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (cnt_clr) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (xfer) begin
      if (br_count != '1)               br_count <= br_count + 1'b1;
      if (mispredict && mp_count != '1) mp_count <= mp_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed-vector bench for branch_resolve with a queue scoreboard and output monitor.
module tb_branch_resolve;
  import branch_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk, rst_n;
  logic             in_valid, in_ready, Equal, Z, N, pred_taken, flush, cnt_clr;
  logic [2:0]       br_op;
  logic [XLEN-1:0]  pc, imm, target, next_pc;
  logic             out_valid, out_ready, taken, illegal, mispredict, redirect;
  logic [CNT_W-1:0] br_count, mp_count;

  typedef struct packed {
    logic        taken;
    logic        illegal;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        mp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  branch_resolve #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Equal(Equal), .Z(Z), .N(N), .br_op(br_op), .pred_taken(pred_taken),
    .pc(pc), .imm(imm), .flush(flush), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .illegal(illegal),
    .target(target), .next_pc(next_pc), .mispredict(mispredict), .redirect(redirect),
    .br_count(br_count), .mp_count(mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every transfer seen at the falling edge pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got target 0x%0h expected no output", target);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {taken, illegal, target, next_pc, mispredict, redirect},
                        {e.taken, e.illegal, e.target, e.next_pc, e.mp, e.mp});
      end
    end
  end

  // Present one branch; push its expected result on the edge it is accepted.
  task automatic issue(input logic [2:0] op, input logic eq, input logic z, input logic n,
                       input logic pred, input logic [31:0] p, input logic [31:0] im,
                       input logic et, input logic ei, input logic [31:0] etgt,
                       input logic [31:0] enext, input logic emp);
    bit done;
    exp_t e;
    br_op = op; Equal = eq; Z = z; N = n; pred_taken = pred; pc = p; imm = im;
    in_valid = 1'b1;
    e = '{taken: et, illegal: ei, target: etgt, next_pc: enext, mp: emp};
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (!flush) sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_total++;
      $display("FAIL issue_timeout: got in_ready 0 for 20 cycles expected 1 (pc 0x%0h)", p);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t dummy;
    rst_n = 0; in_valid = 0; Equal = 0; Z = 0; N = 0; br_op = 3'b000; pred_taken = 0;
    pc = '0; imm = '0; flush = 0; cnt_clr = 0; out_ready = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {taken, illegal, target, next_pc, mispredict, redirect}, 0);
    check("rst_counts", {br_count, mp_count}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // BEQ taken, predicted not taken
    out_ready = 1;
    issue(BR_BEQ, 1, 0, 0, 0, 32'h100, 32'h20, 1, 0, 32'h120, 32'h120, 1);
    in_valid = 0;
    check("beq_valid_redirect", {out_valid, redirect}, 2'b11);
    @(posedge clk); #1;
    check("beq_counts", {br_count, mp_count}, {16'd1, 16'd1});
    check("beq_drained", out_valid, 0);

    // back-to-back at full throughput
    issue(BR_BNE, 1, 0, 0, 0, 32'h200, 32'h40, 0, 0, 32'h240, 32'h204, 0);
    issue(BR_BGE, 0, 1, 0, 1, 32'h300, 32'h10, 1, 0, 32'h310, 32'h310, 0);
    issue(BR_BLT, 0, 1, 1, 0, 32'h400, 32'hFFFF_FFF8, 1, 0, 32'h3F8, 32'h3F8, 1);
    idle();
    check("stream_counts", {br_count, mp_count}, {16'd4, 16'd2});

    // backpressure: second branch waits while the first is held
    out_ready = 0;
    issue(BR_BEQ, 0, 1, 0, 1, 32'h500, 32'h100, 0, 0, 32'h600, 32'h504, 1);
    br_op = BR_JAL; pc = 32'h600; imm = 32'h4; pred_taken = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", {out_valid, taken, target, next_pc, mispredict},
                       {1'b1, 1'b0, 32'h600, 32'h504, 1'b1});
      @(posedge clk); #1;
    end
    out_ready = 1;
    issue(BR_JAL, 0, 1, 0, 1, 32'h600, 32'h4, 1, 0, 32'h604, 32'h604, 0);
    in_valid = 0;
    check("bp_second", {out_valid, target}, {1'b1, 32'h604});
    @(posedge clk); #1;
    check("bp_counts", {br_count, mp_count}, {16'd6, 16'd3});

    // address wrap-around
    issue(BR_JAL, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h8, 1, 0, 32'h4, 32'h4, 0);
    issue(BR_BEQ, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h8, 0, 0, 32'h4, 32'h0, 0);
    idle();
    check("wrap_counts", {br_count, mp_count}, {16'd8, 16'd3});

    // flush of a held entry
    out_ready = 0;
    issue(BR_BNE, 0, 1, 0, 0, 32'h700, 32'h10, 1, 0, 32'h710, 32'h710, 1);
    in_valid = 0; flush = 1;
    dummy = sb.pop_front();
    @(posedge clk); #1;
    flush = 0;
    check("flush_held", {out_valid, redirect}, 2'b00);
    check("flush_held_counts", {br_count, mp_count}, {16'd8, 16'd3});

    // flush discards a same-cycle accept
    out_ready = 1;
    br_op = BR_JAL; pc = 32'h720; imm = 32'h4; pred_taken = 0; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    check("flush_accept", out_valid, 0);

    // flush coinciding with a transfer still counts it
    issue(BR_BGE, 0, 1, 1, 0, 32'h800, 32'h20, 0, 0, 32'h820, 32'h804, 0);
    in_valid = 0; flush = 1;
    @(posedge clk); #1;
    flush = 0;
    check("flush_xfer", out_valid, 0);
    check("flush_xfer_counts", {br_count, mp_count}, {16'd9, 16'd3});

    // undefined opcodes
    issue(3'b111, 1, 0, 0, 1, 32'h900, 32'h10, 0, 1, 32'h910, 32'h904, 1);
    issue(3'b101, 1, 0, 1, 0, 32'hA00, 32'h40, 0, 1, 32'hA40, 32'hA04, 0);
    idle();
    check("illegal_counts", {br_count, mp_count}, {16'd11, 16'd4});

    // saturate the branch counter
    for (int i = 0; i < 65530; i++)
      issue(BR_JAL, 0, 0, 0, 1, 32'h1000, 32'h8, 1, 0, 32'h1008, 32'h1008, 0);
    idle();
    check("sat_counts", {br_count, mp_count}, {16'hFFFF, 16'd4});

    // clear wins over a simultaneous transfer
    issue(BR_JAL, 0, 0, 0, 1, 32'h1000, 32'h8, 1, 0, 32'h1008, 32'h1008, 0);
    in_valid = 0; cnt_clr = 1;
    @(posedge clk); #1;
    cnt_clr = 0;
    check("clr_counts", {br_count, mp_count}, 0);
    issue(BR_BEQ, 1, 0, 0, 0, 32'h40, 32'h10, 1, 0, 32'h50, 32'h50, 1);
    idle();
    check("post_clr_counts", {br_count, mp_count}, {16'd1, 16'd1});

    // async reset mid-stream
    out_ready = 0;
    issue(BR_JAL, 0, 0, 0, 0, 32'h2000, 32'h10, 1, 0, 32'h2010, 32'h2010, 1);
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    #2;
    rst_n = 0;
    sb.delete();
    #1;
    check("async_rst_outputs", {out_valid, taken, illegal, target, next_pc, mispredict, redirect}, 0);
    check("async_rst_counts", {br_count, mp_count}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1;
    issue(BR_BNE, 0, 1, 0, 1, 32'h3000, 32'h100, 1, 0, 32'h3100, 32'h3100, 0);
    idle();
    check("post_rst_counts", {br_count, mp_count}, {16'd1, 16'd0});

    @(posedge clk); #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
